// File: rtl/huffman_serializer.sv
// Transmit side of the Huffman bit link: looks up the fixed prefix code of a
// 4-bit signed symbol and shifts it out MSB first, followed by an idle gap.
module huffman_serializer #(
  parameter int MAX_CODE   = 9,
  parameter int GAP_CYCLES = 2,
  parameter int CNT_W      = 16,
  localparam int LEN_W     = $clog2(MAX_CODE + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [3:0]       in_sym,
  output logic             in_ready,
  input  logic             hold,
  output logic             load,
  output logic             out_bit,
  output logic             last,
  output logic [LEN_W-1:0] code_len,
  output logic [CNT_W-1:0] bit_total
);

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

  state_t                state;
  logic [MAX_CODE-1:0]   code_r;
  logic [LEN_W-1:0]      rem;
  logic [3:0]            gap_cnt;

  logic [MAX_CODE-1:0]   lu_code;
  logic [LEN_W-1:0]      lu_len;
  logic                  accept;
  logic [MAX_CODE-1:0]   cur_code;
  logic [LEN_W-1:0]      cur_rem;
  logic [LEN_W-1:0]      bit_idx;

  // Codebook, right-justified.
  always_comb begin
    lu_code = '0;
    lu_len  = '0;
    case (in_sym)
      4'h8: begin lu_code = MAX_CODE'(9'b111110010); lu_len = LEN_W'(9); end
      4'h9: begin lu_code = MAX_CODE'(9'b011111000); lu_len = LEN_W'(8); end
      4'hA: begin lu_code = MAX_CODE'(9'b001011000); lu_len = LEN_W'(7); end
      4'hB: begin lu_code = MAX_CODE'(9'b000101101); lu_len = LEN_W'(6); end
      4'hC: begin lu_code = MAX_CODE'(9'b000010111); lu_len = LEN_W'(5); end
      4'hD: begin lu_code = MAX_CODE'(9'b000001010); lu_len = LEN_W'(4); end
      4'hE: begin lu_code = MAX_CODE'(9'b000001101); lu_len = LEN_W'(4); end
      4'hF: begin lu_code = MAX_CODE'(9'b000001110); lu_len = LEN_W'(4); end
      4'h0: begin lu_code = MAX_CODE'(9'b000000000); lu_len = LEN_W'(1); end
      4'h1: begin lu_code = MAX_CODE'(9'b000000100); lu_len = LEN_W'(3); end
      4'h2: begin lu_code = MAX_CODE'(9'b000001100); lu_len = LEN_W'(4); end
      4'h3: begin lu_code = MAX_CODE'(9'b000011110); lu_len = LEN_W'(5); end
      4'h4: begin lu_code = MAX_CODE'(9'b000111111); lu_len = LEN_W'(6); end
      4'h5: begin lu_code = MAX_CODE'(9'b001111101); lu_len = LEN_W'(7); end
      4'h6: begin lu_code = MAX_CODE'(9'b001011001); lu_len = LEN_W'(7); end
      4'h7: begin lu_code = MAX_CODE'(9'b111110011); lu_len = LEN_W'(9); end
      default: begin lu_code = '0; lu_len = '0; end
    endcase
  end

  // The accept edge already emits the first bit, so it shares the shift path
  // with the freshly looked-up code instead of the latched one.
  always_comb begin
    accept   = (state == IDLE) && in_ready && in_valid;
    cur_code = accept ? lu_code : code_r;
    cur_rem  = accept ? lu_len : rem;
    bit_idx  = cur_rem - LEN_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      code_r    <= '0;
      rem       <= '0;
      gap_cnt   <= '0;
      in_ready  <= 1'b0;
      load      <= 1'b0;
      out_bit   <= 1'b0;
      last      <= 1'b0;
      code_len  <= '0;
      bit_total <= '0;
    end else begin
      case (state)
        IDLE: begin
          load     <= 1'b0;
          last     <= 1'b0;
          out_bit  <= 1'b0;
          in_ready <= 1'b1;
          if (accept) begin
            in_ready <= 1'b0;
            code_len <= lu_len;
          end
        end
        SHIFT: ;
        GAP: begin
          load    <= 1'b0;
          last    <= 1'b0;
          out_bit <= 1'b0;
          if (gap_cnt == 4'd0) begin
            state    <= IDLE;
            in_ready <= 1'b1;
          end else begin
            gap_cnt <= gap_cnt - 4'd1;
          end
        end
        default: state <= IDLE;
      endcase

      if (accept || state == SHIFT) begin
        code_r <= cur_code;
        state  <= SHIFT;
        if (hold) begin
          load <= 1'b0;
          last <= 1'b0;
          rem  <= cur_rem;
        end else begin
          load      <= 1'b1;
          out_bit   <= cur_code[bit_idx];
          last      <= (cur_rem == LEN_W'(1));
          rem       <= bit_idx;
          bit_total <= bit_total + CNT_W'(1);
          if (cur_rem == LEN_W'(1)) begin
            state   <= GAP;
            gap_cnt <= 4'(GAP_CYCLES);
          end
        end
      end
    end
  end

endmodule

// File: doc/huffman_serializer.md
Name: huffman_serializer

Overview:
- Transmit side of the Huffman bit link: accepts one 4-bit signed symbol (-8..7), looks up its fixed prefix code (1-9 bits) and emits it serially, MSB first.
- The output is one bit per cycle with a load strobe, in the same form the receive-side shift register (load/in_bit) consumes.
- A programmable gap of idle cycles follows every code so the receiver can latch and clear between codes.
- Sits between the symbol source (quantiser/difference stage) and the bit link.

Parameters:
- MAX_CODE, 9: maximum code length in bits; sets width of the code register and of code_len.
- GAP_CYCLES, 2: idle cycles (load=0) inserted after the last bit of each code; legal range 1..15.
- CNT_W, 16: width of the bit_total statistics counter.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  symbol on in_sym is valid.
- in_sym  in  4  two's-complement symbol, -8..7.
- in_ready  out  1  serializer can accept a symbol this cycle.
- hold  in  1  stall request; freezes serialization while high.
- load  out  1  out_bit is a valid code bit this cycle.
- out_bit  out  1  current code bit, MSB first.
- last  out  1  high with the final bit of a code (load=1 and last=1 together).
- code_len  out  4  length of the code currently being sent; held until the next accept.
- bit_total  out  CNT_W  running count of bits emitted; wraps modulo 2^CNT_W.

Behaviour:
Codebook (symbol: code, length):
- -8: 111110010, 9
- -7: 11111000, 8
- -6: 1011000, 7
- -5: 101101, 6
- -4: 10111, 5
- -3: 1010, 4
- -2: 1101, 4
- -1: 1110, 4
- 0: 0, 1
- 1: 100, 3
- 2: 1100, 4
- 3: 11110, 5
- 4: 111111, 6
- 5: 1111101, 7
- 6: 1011001, 7
- 7: 111110011, 9

Reset:
- While reset is high, all outputs are 0 (in_ready, load, out_bit, last, code_len, bit_total) and the state is IDLE.
- in_ready rises on the first clk edge after reset deasserts.
- Reset mid-code abandons the partial code with no further bits; the next accepted symbol starts cleanly.

FSM states: IDLE, SHIFT, GAP.
- IDLE:
  - in_ready=1 and load=0.
  - On an edge with in_valid=1: latch the codeword (right-justified) and its length, set the remaining-bit counter to the length, go to SHIFT, drop in_ready.
  - hold does not block acceptance.
- SHIFT:
  - All outputs are registered. The first bit appears in the cycle after the accept edge (latency 1).
  - Each cycle with hold=0: load=1, out_bit = code[remaining-1], counter decrements, bit_total increments.
  - The cycle with remaining=1 also asserts last=1; the next state is GAP.
  - hold=1: load=0, last=0, out_bit held, no advance, bit_total unchanged. Resume is bit-exact with no bits lost or repeated.
- GAP:
  - load=0 for exactly GAP_CYCLES cycles (gap counter, hold ignored), then IDLE.
  - in_ready is 0 throughout GAP.
- Input handshake:
  - Back-to-back symbols: minimum period per symbol is 1 (accept) + len + GAP_CYCLES cycles.
  - in_sym and in_valid are don't-care unless the state is IDLE.
  - Symbols are never dropped or duplicated.
- Other rules:
  - out_bit is 0 whenever load=0 in IDLE/GAP.
  - code_len updates at the accept edge.

Test Plan:
- Reset, then in_sym=0 for one cycle -> one cycle later load=1, out_bit=0, last=1, code_len=1. Then 2 cycles of load=0, then in_ready=1; bit_total=1.
- Send all 16 symbols -8..7 back-to-back with in_valid held high; capture bits on load -> each captured code matches the codebook and its length; last is on the final bit only. bit_total = 9+8+7+6+5+4+4+4+1+3+4+5+6+7+7+9 = 89.
- in_sym=-8, assert hold for 3 cycles after the 4th bit -> load=0 for those 3 cycles, then bits 5-9 = 10010. Full sequence 111110010, code duration 12 cycles.
- in_sym=7, assert reset after the 5th bit -> outputs go to 0 immediately. After release, in_sym=1 -> clean 100, bit_total=3.
- Build with GAP_CYCLES=1, then in_sym=-1 followed by in_sym=2 -> exactly 1 load=0 cycle between the last bit of 1110 and the accept of 2; second code 1100.
- Preload bit_total near 2^CNT_W-1 (force, or reduce CNT_W=4), then send codes totalling 20 bits -> counter wraps to 4.
